word_split_tx: RTL and testbench

//  Transmit end of the split-word link. Accepts a 2*HALF_W-bit word over a ready/valid handshake and drives it

---
 rtl/word_split_pkg.sv | 18 +
 rtl/word_split_tx_gap_counter.sv | 30 +++
 rtl/word_split_tx.sv | 152 +++++++++++++++
 tb/tb_word_split_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/word_split_pkg.sv
// Shared definitions for both ends of the split-word link: beat-sequencing states and default beat width.
package word_split_pkg;

  localparam int HALF_W_DEFAULT = 8;

  // Beat order on the link is always HIGH then LOW; the receiver relies on the same ordering.
  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    GAP
  } tx_state_t;

  function automatic int gap_cnt_width(input int gap_cyc);
    return (gap_cyc > 1) ? $clog2(gap_cyc) : 1;
  endfunction

endpackage

// File: rtl/word_split_tx_gap_counter.sv
// Down-counter that times the inter-word low period on the link; loaded with GAP_CYC-1, done at zero.
module gap_counter
  import word_split_pkg::*;
#(
  parameter int GAP_CYC = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CNT_W = gap_cnt_width(GAP_CYC);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(GAP_CYC - 1);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/word_split_tx.sv
// Transmit end of the split-word link: one-word holding register feeding a HIGH/LOW/GAP beat sequencer.
// Optional even parity on link_par is enabled by defining WORD_SPLIT_PARITY_EN.
module word_split_tx
  import word_split_pkg::*;
#(
  parameter int HALF_W  = HALF_W_DEFAULT,
  parameter int GAP_CYC = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                in_valid,
  input  logic [2*HALF_W-1:0] in_data,
  output logic                in_ready,
  output logic                link_valid,
  output logic [HALF_W-1:0]   link_data,
  output logic                link_par,
  output logic                busy
);

  if (GAP_CYC < 1) begin : g_bad_gap
    $error("word_split_tx: GAP_CYC must be >= 1, receiver needs a low cycle between words");
  end

  tx_state_t           state;
  tx_state_t           next_state;
  logic [2*HALF_W-1:0] hold_reg;
  logic                hold_full;
  logic [HALF_W-1:0]   low_half;
  logic                accept;
  logic                load;
  logic                gap_done;
  logic                gap_load;
  logic                gap_dec;
  logic                link_valid_nxt;
  logic [HALF_W-1:0]   link_data_nxt;

  // Ready is forced low while reset is held so nothing is accepted into a register being cleared.
  assign in_ready = RESET & ~hold_full;
  assign accept   = in_valid & in_ready;
  assign busy     = hold_full | (state != IDLE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_reg  <= in_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // The low half is parked separately so the holding register is free to take the next word.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      low_half <= '0;
    end else if (load) begin
      low_half <= hold_reg[HALF_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_full) begin
          next_state = HIGH;
          load       = 1'b1;
        end
      end
      HIGH: next_state = LOW;
      LOW:  next_state = GAP;
      GAP: begin
        if (gap_done) begin
          if (hold_full) begin
            next_state = HIGH;
            load       = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign gap_load = (state == LOW);
  assign gap_dec  = (state == GAP);

  gap_counter #(
    .GAP_CYC(GAP_CYC)
  ) u_gap_counter (
    .CLK  (CLK),
    .RESET(RESET),
    .load (gap_load),
    .dec  (gap_dec),
    .done (gap_done)
  );

  // Outputs are decoded from the upcoming state and registered, so link_* never see in_* combinationally.
  always_comb begin
    link_valid_nxt = 1'b0;
    link_data_nxt  = link_data;
    unique case (next_state)
      HIGH: begin
        link_valid_nxt = 1'b1;
        link_data_nxt  = hold_reg[2*HALF_W-1:HALF_W];
      end
      LOW: begin
        link_valid_nxt = 1'b1;
        link_data_nxt  = low_half;
      end
      default: begin
        link_valid_nxt = 1'b0;
        link_data_nxt  = link_data;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      link_valid <= 1'b0;
      link_data  <= '0;
    end else begin
      link_valid <= link_valid_nxt;
      link_data  <= link_data_nxt;
    end
  end

`ifdef WORD_SPLIT_PARITY_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      link_par <= 1'b0;
    end else begin
      link_par <= link_valid_nxt ? ^link_data_nxt : 1'b0;
    end
  end
`else
  assign link_par = 1'b0;
`endif

endmodule

// File: tb/tb_word_split_tx.sv
// Self-checking bench for word_split_tx: timing-level reference model, receiver model and randomized traffic.
module tb_word_split_tx;

  localparam int HALF_W = 8;
  localparam int GAP    = 3;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        link_valid;
  logic [7:0]  link_data;
  logic        link_par;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Reference model: words waiting, word on the link and the edge at which its high beat appeared.
  logic [15:0] pend_q[$];
  logic [15:0] exp_ops[$];
  bit          has_cur;
  logic [15:0] cur;
  int          cur_start;
  int          e;
  logic [7:0]  last_data;
  bit          last_accept;
  logic        exp_valid;
  logic [7:0]  exp_data;
  logic        exp_ready;
  logic        exp_busy;

  // Receiver model and beat log.
  bit          rx_have_hi;
  logic [7:0]  rx_hi;
  logic        prev_valid;
  logic [7:0]  beat_data[$];
  int          beat_cyc[$];
  int          cyc;

  word_split_tx #(
    .HALF_W (HALF_W),
    .GAP_CYC(GAP)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .link_valid(link_valid),
    .link_data (link_data),
    .link_par  (link_par),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    pend_q.delete();
    exp_ops.delete();
    has_cur    = 0;
    cur        = '0;
    cur_start  = 0;
    e          = 0;
    last_data  = '0;
    exp_valid  = 0;
    exp_data   = '0;
    exp_ready  = 1;
    exp_busy   = 0;
    rx_have_hi = 0;
    prev_valid = 0;
  endtask

  // One clock edge of the link: a word may start once the previous one has had 2+GAP cycles.
  task automatic modelEdge(input logic v, input logic [15:0] d);
    bit ready;
    ready       = (pend_q.size() == 0);
    last_accept = v && ready;
    e++;
    if (pend_q.size() > 0 && (!has_cur || e >= cur_start + 2 + GAP)) begin
      cur       = pend_q.pop_front();
      has_cur   = 1;
      cur_start = e;
    end
    if (last_accept) pend_q.push_back(d);
    if (has_cur && e == cur_start) begin
      exp_valid = 1;
      exp_data  = cur[15:8];
    end else if (has_cur && e == cur_start + 1) begin
      exp_valid = 1;
      exp_data  = cur[7:0];
      exp_ops.push_back(cur);
    end else begin
      exp_valid = 0;
      exp_data  = last_data;
    end
    last_data = exp_data;
    exp_ready = (pend_q.size() == 0);
    exp_busy  = (pend_q.size() > 0) || (has_cur && e < cur_start + 2 + GAP);
  endtask

  task automatic checkOutput();
    logic        exp_par;
    logic [15:0] op;
`ifdef WORD_SPLIT_PARITY_EN
    exp_par = exp_valid ? ^exp_data : 1'b0;
`else
    exp_par = 1'b0;
`endif
    checkValue("link_valid", link_valid, exp_valid);
    checkValue("link_data", link_data, exp_data);
    checkValue("in_ready", in_ready, exp_ready);
    checkValue("busy", busy, exp_busy);
    checkValue("link_par", link_par, exp_par);
    if (link_valid === 1'b1) begin
      beat_data.push_back(link_data);
      beat_cyc.push_back(cyc);
    end
    if (link_valid === 1'b1 && prev_valid !== 1'b1) begin
      rx_hi      = link_data;
      rx_have_hi = 1;
    end else if (link_valid === 1'b1 && rx_have_hi) begin
      op         = {rx_hi, link_data};
      rx_have_hi = 0;
      if (exp_ops.size() == 0) begin
        checkValue("rx_op_extra", op, 32'hFFFF_FFFF);
      end else begin
        checkValue("rx_op", op, exp_ops.pop_front());
      end
    end
    prev_valid = link_valid;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge CLK);
    cyc++;
    if (RESET) modelEdge(v, d);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0);
  endtask

  task automatic sendWords(input logic [15:0] w0, input logic [15:0] w1, input int budget);
    int idx;
    idx = 0;
    for (int i = 0; i < budget && idx < 2; i++) begin
      applyStimulus(1'b1, (idx == 0) ? w0 : w1);
      if (last_accept) idx++;
    end
    checkValue("send_budget", idx, 2);
  endtask

  initial begin
    logic [15:0] word;
    bit          v;
    cyc = 0;
    modelReset();

    #2;
    checkValue("rst_in_ready", in_ready, 0);
    checkValue("rst_link_valid", link_valid, 0);
    checkValue("rst_busy", busy, 0);
    checkValue("rst_link_data", link_data, 0);
    #10 RESET = 1'b1;

    idle(10);
    checkValue("idle_in_ready", in_ready, 1);

    applyStimulus(1'b1, 16'hA55A);
    applyStimulus(1'b0, 16'h0);
    checkValue("a55a_hi_valid", link_valid, 1);
    checkValue("a55a_hi_data", link_data, 8'hA5);
    applyStimulus(1'b0, 16'h0);
    checkValue("a55a_lo_valid", link_valid, 1);
    checkValue("a55a_lo_data", link_data, 8'h5A);
    applyStimulus(1'b0, 16'h0);
    checkValue("a55a_gap_valid", link_valid, 0);
    idle(4);

    applyStimulus(1'b1, 16'h0701);
    applyStimulus(1'b0, 16'h0);
`ifdef WORD_SPLIT_PARITY_EN
    checkValue("par_hi", link_par, 1);
`else
    checkValue("par_hi_off", link_par, 0);
`endif
    applyStimulus(1'b0, 16'h0);
`ifdef WORD_SPLIT_PARITY_EN
    checkValue("par_lo", link_par, 1);
`else
    checkValue("par_lo_off", link_par, 0);
`endif
    idle(5);

    beat_data.delete();
    beat_cyc.delete();
    sendWords(16'h1234, 16'h5678, 20);
    idle(8);
    checkValue("b2b_beats", beat_data.size(), 4);
    if (beat_data.size() == 4) begin
      checkValue("b2b_b0", beat_data[0], 8'h12);
      checkValue("b2b_b1", beat_data[1], 8'h34);
      checkValue("b2b_b2", beat_data[2], 8'h56);
      checkValue("b2b_b3", beat_data[3], 8'h78);
      checkValue("b2b_gap_len", beat_cyc[2] - beat_cyc[1] - 1, 3);
    end

    word = 16'($urandom);
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(v, word);
      if (last_accept || !v) word = 16'($urandom);
    end
    idle(8);

    applyStimulus(1'b1, 16'hBEEF);
    applyStimulus(1'b1, 16'hC0DE);
    applyStimulus(1'b1, 16'hC0DE);
    checkValue("mid_low_valid", link_valid, 1);
    checkValue("mid_low_data", link_data, 8'hEF);
    in_valid = 1'b0;
    #2 RESET = 1'b0;
    #1;
    checkValue("async_link_valid", link_valid, 0);
    checkValue("async_link_data", link_data, 0);
    checkValue("async_in_ready", in_ready, 0);
    checkValue("async_busy", busy, 0);
    @(posedge CLK);
    @(negedge CLK);
    modelReset();
    RESET = 1'b1;
    idle(2);
    applyStimulus(1'b1, 16'h3C96);
    idle(8);
    checkValue("final_ops_drained", exp_ops.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
